// File: rtl/sd_reg_bank.sv
// SD host controller register bank: N_SLOTS independent register sets behind one CPU port.
// Optional ADMA system-address registers are built when SD_REG_ADMA_EN is defined.
module sd_reg_bank #(
    parameter int N_SLOTS = 1,
    parameter int ADDR_W  = 12
) (
    input  logic                    CLK,
    input  logic                    rst_L,
    input  logic [ADDR_W-1:0]       reg_address,
    input  logic [31:0]             reg_wr_data,
    input  logic [3:0]              reg_be,
    input  logic                    reg_wr_en,
    input  logic                    reg_rd_en,
    output logic [31:0]             reg_rd_data,
    output logic                    reg_rd_valid,
    output logic [N_SLOTS-1:0]      start_flag,
    output logic [16*N_SLOTS-1:0]   blk_size,
    output logic [16*N_SLOTS-1:0]   blk_cnt,
    output logic [16*N_SLOTS-1:0]   tf_mode,
    output logic [16*N_SLOTS-1:0]   command,
    output logic [32*N_SLOTS-1:0]   argument,
    output logic [32*N_SLOTS-1:0]   response,
    input  logic [N_SLOTS-1:0]      blk_cnt_dec,
    input  logic [N_SLOTS-1:0]      resp_wr_en,
    input  logic [32*N_SLOTS-1:0]   resp_wr_data,
    input  logic [32*N_SLOTS-1:0]   psr_in,
    input  logic [15*N_SLOTS-1:0]   nisr_set,
    input  logic [16*N_SLOTS-1:0]   eisr_set,
    output logic [N_SLOTS-1:0]      irq,
    output logic [64*N_SLOTS-1:0]   adma_addr
);

    localparam logic [5:0] W_BLK     = 6'h01;
    localparam logic [5:0] W_ARG     = 6'h02;
    localparam logic [5:0] W_CMD     = 6'h03;
    localparam logic [5:0] W_RESP    = 6'h04;
    localparam logic [5:0] W_PSR     = 6'h09;
    localparam logic [5:0] W_ISR     = 6'h0C;
    localparam logic [5:0] W_ISR_EN  = 6'h0D;
    localparam logic [5:0] W_ADMA_LO = 6'h16;
    localparam logic [5:0] W_ADMA_HI = 6'h17;

    function automatic logic [31:0] merge_be(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [31:0] mask);
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    logic [1:0]             addr_slot;
    logic [5:0]             addr_word;
    logic [31:0]            be_mask;
    logic [32*N_SLOTS-1:0]  slot_rd_flat;
    logic [31:0]            rd_mux;
    logic [31:0]            rd_data_q, rd_data_d;
    logic                   rd_valid_q, rd_valid_d;

    assign addr_slot = reg_address[9:8];
    assign addr_word = reg_address[7:2];
    assign be_mask   = {{8{reg_be[3]}}, {8{reg_be[2]}}, {8{reg_be[1]}}, {8{reg_be[0]}}};

    // Byte-lane bits and any address bits above the slot field carry no decode.
    logic unused_addr_lo;
    assign unused_addr_lo = ^reg_address[1:0];
    if (ADDR_W > 10) begin : g_addr_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^reg_address[ADDR_W-1:10];
    end

    for (genvar gi = 0; gi < N_SLOTS; gi++) begin : g_slot
        logic        wr_sel;
        logic        busy;
        logic [31:0] wr_blk, wr_cmd, wr_arg, wr_isr_en;
        logic [15:0] bsr_q, bsr_d, bcr_q, bcr_d;
        logic [15:0] tmr_q, tmr_d, cr_q, cr_d;
        logic [31:0] arg_q, arg_d, resp_q, resp_d;
        logic [14:0] nisr_q, nisr_d, nisr_clr;
        logic [15:0] eisr_q, eisr_d, eisr_clr;
        logic [15:0] nisr_en_q, nisr_en_d, eisr_en_q, eisr_en_d;
        logic        start_q, start_d, irq_q, irq_d;
        logic [15:0] nisr_rd;
        logic [31:0] rd_word;
        logic [63:0] adma_val;

        assign wr_sel    = reg_wr_en && (addr_slot == 2'(gi));
        assign busy      = psr_in[32*gi];
        assign nisr_rd   = {|eisr_q, nisr_q};
        assign wr_blk    = merge_be({bcr_q, bsr_q}, reg_wr_data, be_mask);
        assign wr_cmd    = merge_be({cr_q, tmr_q}, reg_wr_data, be_mask);
        assign wr_arg    = merge_be(arg_q, reg_wr_data, be_mask);
        assign wr_isr_en = merge_be({eisr_en_q, nisr_en_q}, reg_wr_data, be_mask);

        always_comb begin
            bsr_d     = bsr_q;
            bcr_d     = bcr_q;
            tmr_d     = tmr_q;
            cr_d      = cr_q;
            arg_d     = arg_q;
            resp_d    = resp_q;
            nisr_en_d = nisr_en_q;
            eisr_en_d = eisr_en_q;
            start_d   = 1'b0;
            nisr_clr  = '0;
            eisr_clr  = '0;

            if (wr_sel) begin
                case (addr_word)
                    W_BLK:    bsr_d = wr_blk[15:0];
                    W_ARG:    arg_d = wr_arg;
                    W_CMD: begin
                        tmr_d = wr_cmd[15:0];
                        // A command write while the line is busy is discarded outright.
                        if (!busy) begin
                            cr_d    = wr_cmd[31:16];
                            start_d = reg_be[3];
                        end
                    end
                    W_ISR: begin
                        nisr_clr = reg_wr_data[14:0] & be_mask[14:0];
                        eisr_clr = reg_wr_data[31:16] & be_mask[31:16];
                    end
                    W_ISR_EN: begin
                        nisr_en_d = wr_isr_en[15:0];
                        eisr_en_d = wr_isr_en[31:16];
                    end
                    default: ;
                endcase
            end

            // CPU write to either BCR byte takes priority over the hardware decrement.
            if (wr_sel && (addr_word == W_BLK) && (|reg_be[3:2])) begin
                bcr_d = wr_blk[31:16];
            end else if (blk_cnt_dec[gi] && (bcr_q != 16'd0)) begin
                bcr_d = bcr_q - 16'd1;
            end

            if (resp_wr_en[gi]) begin
                resp_d = resp_wr_data[32*gi +: 32];
            end

            // Set pulses win over a same-cycle write-1-to-clear.
            nisr_d = (nisr_q & ~nisr_clr) | nisr_set[15*gi +: 15];
            eisr_d = (eisr_q & ~eisr_clr) | eisr_set[16*gi +: 16];
            irq_d  = (|(nisr_rd & nisr_en_q)) || (|(eisr_q & eisr_en_q));

            case (addr_word)
                W_BLK:     rd_word = {bcr_q, bsr_q};
                W_ARG:     rd_word = arg_q;
                W_CMD:     rd_word = {cr_q, tmr_q};
                W_RESP:    rd_word = resp_q;
                W_PSR:     rd_word = psr_in[32*gi +: 32];
                W_ISR:     rd_word = {eisr_q, nisr_rd};
                W_ISR_EN:  rd_word = {eisr_en_q, nisr_en_q};
                W_ADMA_LO: rd_word = adma_val[31:0];
                W_ADMA_HI: rd_word = adma_val[63:32];
                default:   rd_word = '0;
            endcase
        end

        always_ff @(posedge CLK or negedge rst_L) begin
            if (!rst_L) begin
                bsr_q     <= '0;
                bcr_q     <= '0;
                tmr_q     <= '0;
                cr_q      <= '0;
                arg_q     <= '0;
                resp_q    <= '0;
                nisr_q    <= '0;
                eisr_q    <= '0;
                nisr_en_q <= '0;
                eisr_en_q <= '0;
                start_q   <= 1'b0;
                irq_q     <= 1'b0;
            end else begin
                bsr_q     <= bsr_d;
                bcr_q     <= bcr_d;
                tmr_q     <= tmr_d;
                cr_q      <= cr_d;
                arg_q     <= arg_d;
                resp_q    <= resp_d;
                nisr_q    <= nisr_d;
                eisr_q    <= eisr_d;
                nisr_en_q <= nisr_en_d;
                eisr_en_q <= eisr_en_d;
                start_q   <= start_d;
                irq_q     <= irq_d;
            end
        end

`ifdef SD_REG_ADMA_EN
        logic [31:0] adma_lo_q, adma_lo_d, adma_hi_q, adma_hi_d;

        always_comb begin
            adma_lo_d = adma_lo_q;
            adma_hi_d = adma_hi_q;
            if (wr_sel && (addr_word == W_ADMA_LO)) begin
                adma_lo_d = merge_be(adma_lo_q, reg_wr_data, be_mask);
            end
            if (wr_sel && (addr_word == W_ADMA_HI)) begin
                adma_hi_d = merge_be(adma_hi_q, reg_wr_data, be_mask);
            end
        end

        always_ff @(posedge CLK or negedge rst_L) begin
            if (!rst_L) begin
                adma_lo_q <= '0;
                adma_hi_q <= '0;
            end else begin
                adma_lo_q <= adma_lo_d;
                adma_hi_q <= adma_hi_d;
            end
        end

        assign adma_val = {adma_hi_q, adma_lo_q};
`else
        assign adma_val = '0;
`endif

        assign slot_rd_flat[32*gi +: 32] = rd_word;
        assign start_flag[gi]            = start_q;
        assign irq[gi]                   = irq_q;
        assign blk_size[16*gi +: 16]     = {4'b0000, bsr_q[11:0]};
        assign blk_cnt[16*gi +: 16]      = bcr_q;
        assign tf_mode[16*gi +: 16]      = tmr_q;
        assign command[16*gi +: 16]      = cr_q;
        assign argument[32*gi +: 32]     = arg_q;
        assign response[32*gi +: 32]     = resp_q;
        assign adma_addr[64*gi +: 64]    = adma_val;
    end

    // Slots beyond N_SLOTS match no entry and so read back zero.
    always_comb begin
        rd_mux = '0;
        for (int s = 0; s < N_SLOTS; s++) begin
            if (addr_slot == 2'(s)) begin
                rd_mux = slot_rd_flat[32*s +: 32];
            end
        end
        rd_data_d  = reg_rd_en ? rd_mux : rd_data_q;
        rd_valid_d = reg_rd_en;
    end

    always_ff @(posedge CLK or negedge rst_L) begin
        if (!rst_L) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign reg_rd_data  = rd_data_q;
    assign reg_rd_valid = rd_valid_q;

endmodule

// File: doc/sd_reg_bank.md
SD_REG_BANK -- requirements
Module: sd_reg_bank

Interface
REQ-001 Parameter N_SLOTS, default 1, number of independent SD slot register sets (legal 1..4).
REQ-002 Parameter ADDR_W, default 12, CPU byte-address width.
REQ-003 CLK  input  1  single clock; all state on rising edge.
REQ-004 rst_L  input  1  asynchronous, active-low reset.
REQ-005 reg_address  input  ADDR_W  byte address: [9:8] slot, [7:2] word, [1:0] ignored.
REQ-006 reg_wr_data  input  32  CPU write data.
REQ-007 reg_be  input  4  byte enables for the write.
REQ-008 reg_wr_en / reg_rd_en  input  1 each  one-cycle write / read strobes.
REQ-009 reg_rd_data  output  32  registered read data.
REQ-010 reg_rd_valid  output  1  qualifies reg_rd_data.
REQ-011 start_flag  output  N_SLOTS  one-cycle command-start pulse per slot.
REQ-012 blk_size, blk_cnt, tf_mode, command  output  16*N_SLOTS each  register contents.
REQ-013 argument, response  output  32*N_SLOTS each  register contents.
REQ-014 blk_cnt_dec, resp_wr_en  input  N_SLOTS each  hardware decrement / response load strobes.
REQ-015 resp_wr_data, psr_in  input  32*N_SLOTS each  response value / live present state.
REQ-016 nisr_set  input  15*N_SLOTS; eisr_set  input  16*N_SLOTS  interrupt status set pulses.
REQ-017 irq  output  N_SLOTS  per-slot interrupt.
REQ-018 adma_addr  output  64*N_SLOTS  ADMA system address.

Function
REQ-019 Per-slot word map: 0x04 {BCR,BSR}; 0x08 argument; 0x0C {CR,TMR}; 0x10 response (RO); 0x24 PSR (RO, reads psr_in); 0x30 {EISR,NISR} (RW1C); 0x34 {EISR_EN,NISR_EN}; 0x58/0x5C ADMA address low/high.
REQ-020 CPU writes update only bytes with reg_be set; unmapped words, RO words, slots >= N_SLOTS ignore writes and read 0.
REQ-021 Read: reg_rd_en in cycle N -> reg_rd_data and reg_rd_valid=1 in cycle N+1; reg_rd_valid=0 otherwise; simultaneous write and read to same word returns the pre-write value.
REQ-022 start_flag[s] pulses for exactly the cycle after a write with reg_be[3]=1 to slot s word 0x0C while psr_in[s][0]=0.
REQ-023 Write to CR while psr_in[s][0]=1 is dropped entirely (TMR bytes of same write still land); no start_flag.
REQ-024 blk_cnt_dec decrements BCR by 1 per cycle, saturating at 0; same-cycle CPU write to BCR wins.
REQ-025 resp_wr_en loads response from resp_wr_data next cycle.
REQ-026 nisr_set/eisr_set bits set status; writing 1 clears; same-cycle set and clear leaves bit set.
REQ-027 NISR[15] is read-only, equal to |EISR; bits [14:0] stored.
REQ-028 irq[s] = |(NISR & NISR_EN) | |(EISR & EISR_EN), registered, one cycle after status change.
REQ-029 blk_size output carries BSR[11:0] zero-extended; bits [15:12] read as written.

Reset
REQ-030 rst_L low asynchronously clears all registers, reg_rd_data, reg_rd_valid, start_flag, irq to 0.
REQ-031 Reset asserted mid-read suppresses reg_rd_valid; a pending start_flag is not emitted after release.

Configuration
REQ-032 Macro SD_REG_ADMA_EN: defined -> ADMA address words 0x58/0x5C are RW per slot and drive adma_addr.
REQ-033 Undefined -> no ADMA storage, words 0x58/0x5C read 0 and ignore writes, adma_addr tied 0.

Verification
REQ-034 Write 0x0C data 0x1A00_0012 be=0xF, psr_in[0]=0 -> next cycle start_flag=1 for one cycle, command=0x1A00, tf_mode=0x0012.
REQ-035 Same write with psr_in[0][0]=1 -> command unchanged, tf_mode=0x0012, no start_flag.
REQ-036 eisr_set bit0 pulse, EISR_EN=0x0001 -> EISR=0x0001, NISR[15]=1, irq=1; write 0x0001_0000 to 0x30 -> EISR=0, irq=0 next cycle.
REQ-037 BCR=1, blk_cnt_dec held 3 cycles -> BCR=0, no wrap to 0xFFFF; CPU write 0x0005 with concurrent dec -> BCR=5.
REQ-038 N_SLOTS=2: write argument 0xDEADBEEF to address 0x108 -> slot1 argument=0xDEADBEEF, slot0 unchanged; read 0x308 -> 0, reg_rd_valid=1.
REQ-039 With SD_REG_ADMA_EN, write 0x1000 to 0x58, 0x1 to 0x5C -> adma_addr=0x0000_0001_0000_1000; without macro -> reads 0.
